spi_readback_tx: RTL and testbench
==================================

# spi_readback_tx

SPI-peripheral read path that returns configuration-register contents to the SPI controller on MISO. It decodes the 8-bit command byte, selects one byte from the flattened register bank, snapshots it, and shifts it out MSB-first in SPI mode 0. The latched register bank holds the data; this block only reads it, so a write command is ignored here.

## Interface
- NUM_REGS, default 16: number of 8-bit registers in `reg_bank`; valid addresses are 0..NUM_REGS-1 (NUM_REGS ≤ 128).
- DVDD  inout  1: local digital supply.
- DVSS  inout  1: local digital ground.
- clk  input  1: system clock; frequency must be at least 8× SCLK.
- rstn  input  1: asynchronous, active-low reset.
- spi_cs_n  input  1: chip select, active low, asynchronous to `clk`.
- spi_sclk  input  1: SPI clock, asynchronous to `clk`, idle low (mode 0).
- spi_mosi  input  1: controller data; sampled on the SCLK rising edge.
- reg_bank  input  NUM_REGS*8: flattened register contents; register k is bits [8k+7:8k].
- spi_miso  output  1: read data, MSB first.
- miso_oe  output  1: pad output enable; 1 only while a read byte is being shifted.
- rd_strobe  output  1: one-`clk` pulse when a valid read address is latched.
- rd_addr  output  7: address of the last valid read command.

## Operation
- Synchronization:
  - `spi_cs_n`, `spi_sclk` and `spi_mosi` each pass through a 2-flop synchronizer.
  - SCLK rise and fall events come from a third flop plus edge detect.
  - MOSI is sampled from its synchronized value at the detected rise.
- Command byte (8 bits, MSB first):
  - bit7 = R/W (1 = read).
  - bits6:0 = address.
- States:
  - IDLE: outputs quiescent. A synchronized `cs_n` falling edge clears the bit counter and moves to CMD.
  - CMD: shift MOSI into the command register on each SCLK rise. After the 8th rise:
    - Read with address < NUM_REGS: load the shift register with `reg_bank[addr]`, set `rd_addr`, pulse `rd_strobe`, assert `miso_oe`, go to DATA.
    - Read with address ≥ NUM_REGS: load 0x00, assert `miso_oe`, leave `rd_addr` unchanged, no `rd_strobe`, go to DATA.
    - Write (bit7 = 0): go to DONE with `miso_oe` = 0.
  - DATA:
    - `spi_miso` = shift[7].
    - Each SCLK rise sets `shift_pend`. The next SCLK fall shifts left by 1 (zero fill) and clears `shift_pend`.
    - The 8th data rise moves to DONE; no shift occurs on the fall that follows.
  - DONE: `miso_oe` = 0 and `spi_miso` = 0. Further SCLK edges are ignored until `cs_n` rises.
- A synchronized `cs_n` rise in any state returns to IDLE. This clears `miso_oe`, `spi_miso`, the counters and `shift_pend`, which aborts a partial transfer.
- The byte is snapshotted at load. Changes to `reg_bank` during DATA do not affect the byte being shifted.
- Each `cs_n` low period carries one command. There is no auto-increment.

## Timing
- Reset (`rstn` = 0, asynchronous): state IDLE, `spi_miso` 0, `miso_oe` 0, `rd_strobe` 0, `rd_addr` 0, shift register 0, counters 0.
- Pin-to-event latency is 3 `clk`: a SCLK or CS edge is acted on in the 3rd `clk` after the pin edge.
- The first read bit (bit7) is valid on `spi_miso` 1 `clk` after the internal 8th-command-rise event. That is 4 `clk` after the pin edge, well before the 9th SCLK rise.
- Each later bit updates 1 `clk` after its internal fall event, i.e. 4 `clk` after the SCLK falling pin edge.
- `rd_strobe` is high for exactly 1 `clk`, in the same cycle that `miso_oe` first goes to 1.
- CS deassertion: `miso_oe` drops within 4 `clk` of the `cs_n` pin rising edge.
- Simultaneous SCLK event and CS rise in the same `clk`: CS wins, the SCLK event is discarded, and the next state is IDLE.
- Reset asserted mid-transfer: outputs go to their reset values immediately (asynchronously). After `rstn` releases, the block waits for a fresh `cs_n` falling edge; if CS is already low, nothing happens until CS goes high and then low again.

## Test plan
- Valid read: NUM_REGS = 16, reg[5] = 0xA5. Send command 0x85 at SCLK = clk/8 -> MISO bits 1,0,1,0,0,1,0,1. `rd_strobe` pulses once. `rd_addr` = 5. `miso_oe` is high for exactly 8 data bits, then low.
- Write command: send 0x05 followed by 8 data bits -> `miso_oe` stays 0, no `rd_strobe`, `rd_addr` unchanged.
- Out-of-range read: send command 0xFF -> MISO shifts 0x00, `miso_oe` = 1 during data, no `rd_strobe`.
- Snapshot: start a read of reg[3] = 0x3C and change reg[3] to 0xC3 after the 2nd data bit -> MISO still shifts 0x3C.
- CS abort: raise `cs_n` after 3 data bits -> `miso_oe` = 0 within 4 `clk`. A following read of reg[0] = 0x81 returns 0x81 correctly.
- Reset mid-transfer: pull `rstn` low during DATA -> all outputs immediately 0. The next full transaction reads correctly.

Source files
------------

// File: rtl/spi_readback_tx.sv
// SPI mode-0 read path: decodes a command byte on MOSI and shifts one snapshotted
// register-bank byte back out on MISO, MSB first. Write commands are ignored here.
module spi_readback_tx #(
    parameter int NUM_REGS = 16
) (
    inout  wire                    DVDD,
    inout  wire                    DVSS,
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   spi_cs_n,
    input  logic                   spi_sclk,
    input  logic                   spi_mosi,
    input  logic [NUM_REGS*8-1:0]  reg_bank,
    output logic                   spi_miso,
    output logic                   miso_oe,
    output logic                   rd_strobe,
    output logic [6:0]             rd_addr
);

    // state  | meaning
    // S_IDLE | waiting for a synchronized cs_n falling edge
    // S_CMD  | shifting in the 8-bit command byte
    // S_DATA | shifting the snapshotted read byte out on MISO
    // S_DONE | transfer finished, ignore SCLK until cs_n rises
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cs_sync_q, sclk_sync_q;
    logic [1:0]  mosi_sync_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  cmd_q, cmd_d;
    logic [7:0]  shift_q, shift_d;
    logic        pend_q, pend_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        strobe_q, strobe_d;
    logic [6:0]  addr_q, addr_d;

    logic        cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [7:0]  cmd_full;
    logic [7:0]  rd_byte;
    logic        rd_hit;

    wire unused_supply = DVDD ^ DVSS;

    // CS sync resets low so a CS already low at reset release is not seen as a fresh select
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs_sync_q   <= 3'b000;
            sclk_sync_q <= 3'b000;
            mosi_sync_q <= 2'b00;
        end else begin
            cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
        end
    end

    assign cs_fall   = ~cs_sync_q[1] &  cs_sync_q[2];
    assign cs_rise   =  cs_sync_q[1] & ~cs_sync_q[2];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign cmd_full  = {cmd_q, mosi_sync_q[1]};

    always_comb begin
        rd_hit  = 1'b0;
        rd_byte = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (cmd_full[6:0] == 7'(k)) begin
                rd_hit  = 1'b1;
                rd_byte = reg_bank[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_d     = cmd_q;
        shift_d   = shift_q;
        pend_d    = pend_q;
        oe_d      = oe_q;
        strobe_d  = 1'b0;
        addr_d    = addr_q;
        miso_d    = (state_q == S_DATA) && !cs_rise ? shift_q[7] : 1'b0;

        if (cs_rise) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            pend_d    = 1'b0;
            oe_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        bit_cnt_d = 3'd0;
                        state_d   = S_CMD;
                    end
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        cmd_d     = cmd_full[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (cmd_full[7]) begin
                                shift_d = rd_hit ? rd_byte : 8'h00;
                                oe_d    = 1'b1;
                                state_d = S_DATA;
                                if (rd_hit) begin
                                    strobe_d = 1'b1;
                                    addr_d   = cmd_full[6:0];
                                end
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DATA: begin
                    // MISO changes on the fall after each rise so the controller samples stable data
                    if (sclk_rise) begin
                        pend_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            pend_d  = 1'b0;
                            oe_d    = 1'b0;
                            state_d = S_DONE;
                        end
                    end else if (sclk_fall && pend_q) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        pend_d  = 1'b0;
                    end
                end
                S_DONE: begin
                    oe_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            cmd_q     <= 7'd0;
            shift_q   <= 8'h00;
            pend_q    <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            strobe_q  <= 1'b0;
            addr_q    <= 7'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_q     <= cmd_d;
            shift_q   <= shift_d;
            pend_q    <= pend_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            strobe_q  <= strobe_d;
            addr_q    <= addr_d;
        end
    end

    assign spi_miso  = miso_q;
    assign miso_oe   = oe_q;
    assign rd_strobe = strobe_q;
    assign rd_addr   = addr_q;

endmodule

// File: tb/tb_spi_readback_tx.sv
// Directed bench for spi_readback_tx: SCLK = clk/8, MISO sampled just before each SCLK rise.
module tb_spi_readback_tx;

    localparam int NUM_REGS = 16;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  spi_cs_n, spi_sclk, spi_mosi;
    logic [NUM_REGS*8-1:0] reg_bank;
    logic                  spi_miso, miso_oe, rd_strobe;
    logic [6:0]            rd_addr;
    wire                   DVDD, DVSS;

    assign DVDD = 1'b1;
    assign DVSS = 1'b0;

    spi_readback_tx #(.NUM_REGS(NUM_REGS)) dut (
        .DVDD      (DVDD),
        .DVSS      (DVSS),
        .clk       (clk),
        .rstn      (rstn),
        .spi_cs_n  (spi_cs_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .reg_bank  (reg_bank),
        .spi_miso  (spi_miso),
        .miso_oe   (miso_oe),
        .rd_strobe (rd_strobe),
        .rd_addr   (rd_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cyc  = 0;
    int strobe_algn = 0;
    logic oe_prev = 1'b0;

    // strobe must last one clk and coincide with miso_oe first rising
    always @(negedge clk) begin
        if (rd_strobe) strobe_cyc++;
        if (rd_strobe && miso_oe && !oe_prev) strobe_algn++;
        oe_prev = miso_oe;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within 500 us");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sbit(input logic mosi_v, output logic miso_s, output logic oe_s);
        spi_mosi = mosi_v;
        #39;
        miso_s = spi_miso;
        oe_s   = miso_oe;
        #1 spi_sclk = 1'b1;
        #40 spi_sclk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] cmd, input int ndata, input int chg_at,
                        input logic [7:0] chg_val, output logic [7:0] rx, output int oe_cnt);
        logic m, o;
        rx = 8'h00;
        oe_cnt = 0;
        @(posedge clk);
        #3 spi_cs_n = 1'b0;
        #80;
        for (int i = 0; i < 8; i++) sbit(cmd[7-i], m, o);
        for (int j = 0; j < ndata; j++) begin
            if (j == chg_at) reg_bank[31:24] = chg_val;
            sbit(1'b0, m, o);
            rx = {rx[6:0], m};
            oe_cnt += int'(o);
        end
    endtask

    task automatic cs_release();
        spi_cs_n = 1'b1;
        #120;
    endtask

    initial begin
        logic [7:0] rx;
        int oe_cnt, s0, a0;
        logic m, o;

        rstn = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) reg_bank[8*k +: 8] = 8'(8'h10 + k);
        reg_bank[7:0]   = 8'h81;
        reg_bank[31:24] = 8'h3C;
        reg_bank[47:40] = 8'hA5;
        reg_bank[63:56] = 8'hFF;

        #22;
        chk("reset_miso",   16'(spi_miso),  16'h0);
        chk("reset_oe",     16'(miso_oe),   16'h0);
        chk("reset_strobe", 16'(rd_strobe), 16'h0);
        chk("reset_addr",   16'(rd_addr),   16'h0);
        #25 rstn = 1'b1;
        #100;

        // valid read of reg 5
        s0 = strobe_cyc; a0 = strobe_algn;
        xfer(8'h85, 8, -1, 8'h00, rx, oe_cnt);
        chk("rd5_data",   16'(rx), 16'hA5);
        chk("rd5_oe_cnt", 16'(oe_cnt), 16'd8);
        chk("rd5_strobe", 16'(strobe_cyc - s0), 16'd1);
        chk("rd5_strobe_align", 16'(strobe_algn - a0), 16'd1);
        chk("rd5_addr",   16'(rd_addr), 16'd5);
        #60;
        chk("rd5_oe_after",   16'(miso_oe),  16'h0);
        chk("rd5_miso_after", 16'(spi_miso), 16'h0);
        cs_release();

        // write command is ignored
        s0 = strobe_cyc;
        xfer(8'h05, 8, -1, 8'h00, rx, oe_cnt);
        chk("wr_oe_cnt", 16'(oe_cnt), 16'd0);
        chk("wr_strobe", 16'(strobe_cyc - s0), 16'd0);
        chk("wr_addr",   16'(rd_addr), 16'd5);
        cs_release();

        // out-of-range read shifts zeros
        s0 = strobe_cyc;
        xfer(8'hFF, 8, -1, 8'h00, rx, oe_cnt);
        chk("oor_data",   16'(rx), 16'h00);
        chk("oor_oe_cnt", 16'(oe_cnt), 16'd8);
        chk("oor_strobe", 16'(strobe_cyc - s0), 16'd0);
        chk("oor_addr",   16'(rd_addr), 16'd5);
        cs_release();

        // snapshot: reg 3 changes after the 2nd data bit
        xfer(8'h83, 8, 2, 8'hC3, rx, oe_cnt);
        chk("snap_data", 16'(rx), 16'h3C);
        chk("snap_addr", 16'(rd_addr), 16'd3);
        cs_release();

        // CS abort after 3 data bits of reg 5
        xfer(8'h85, 3, -1, 8'h00, rx, oe_cnt);
        chk("abort_bits", 16'(rx), 16'h05);
        spi_cs_n = 1'b1;
        #35;
        chk("abort_oe_4clk", 16'(miso_oe), 16'h0);
        #85;
        chk("abort_miso", 16'(spi_miso), 16'h0);
        s0 = strobe_cyc;
        xfer(8'h80, 8, -1, 8'h00, rx, oe_cnt);
        chk("post_abort_data", 16'(rx), 16'h81);
        chk("post_abort_addr", 16'(rd_addr), 16'd0);
        chk("post_abort_strobe", 16'(strobe_cyc - s0), 16'd1);
        cs_release();

        // reset in the middle of a read of reg 7 (0xFF)
        xfer(8'h87, 3, -1, 8'h00, rx, oe_cnt);
        #20;
        chk("pre_rst_oe",   16'(miso_oe),  16'h1);
        chk("pre_rst_miso", 16'(spi_miso), 16'h1);
        chk("pre_rst_addr", 16'(rd_addr),  16'd7);
        rstn = 1'b0;
        #1;
        chk("rst_mid_miso", 16'(spi_miso), 16'h0);
        chk("rst_mid_oe",   16'(miso_oe),  16'h0);
        chk("rst_mid_addr", 16'(rd_addr),  16'h0);
        #50 rstn = 1'b1;
        #100;
        // CS still low: clocking a full read must not start a transfer
        s0 = strobe_cyc;
        oe_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            sbit((i < 8) ? m_bit(8'h87, i) : 1'b0, m, o);
            oe_cnt += int'(o);
        end
        chk("stale_cs_oe_cnt", 16'(oe_cnt), 16'd0);
        chk("stale_cs_strobe", 16'(strobe_cyc - s0), 16'd0);
        cs_release();
        xfer(8'h85, 8, -1, 8'h00, rx, oe_cnt);
        chk("post_rst_data", 16'(rx), 16'hA5);
        chk("post_rst_addr", 16'(rd_addr), 16'd5);
        chk("post_rst_oe_cnt", 16'(oe_cnt), 16'd8);
        cs_release();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic m_bit(input logic [7:0] b, input int i);
        return b[7-i];
    endfunction

endmodule
